// File: rtl/pos_pkg.sv
// Shared definitions for the POS keypad path: key codes, grid geometry,
// entry FSM encoding and the cursor-to-key decoder.
package pos_pkg;

    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;

    localparam logic [3:0] GRID_COLS = 4'd3;
    localparam logic [3:0] GRID_ROWS = 4'd4;

    localparam logic [0:0] S_ENTRY = 1'b0;
    localparam logic [0:0] S_OUT   = 1'b1;

    // Returns {valid, code}; valid is 0 when the cursor is off the grid.
    function automatic logic [4:0] decode_key(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] res;
        res = 5'd0;
        if ((x >= GRID_COLS) || (y >= GRID_ROWS)) begin
            res = 5'd0;
        end else if (y == (GRID_ROWS - 4'd1)) begin
            if (x == 4'd0) begin
                res = {1'b1, KEY_CLEAR};
            end else if (x == 4'd1) begin
                res = {1'b1, 4'd0};
            end else begin
                res = {1'b1, KEY_ENTER};
            end
        end else begin
            res = {1'b1, 4'((y << 1) + y + x + 4'd1)};
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low button;
// emits a one-cycle pulse when the debounced level falls (press).
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             s1_r;
    logic             s2_r;
    logic             db_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronise, count consecutive differing cycles, commit the new level.
    // The commit lands DB_CYCLES edges after s2 first differs from db.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r    <= 1'b1;
            s2_r    <= 1'b1;
            db_r    <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            press_r <= 1'b0;
        end else begin
            s1_r    <= btn_n;
            s2_r    <= s1_r;
            press_r <= 1'b0;
            if (s2_r == db_r) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (cnt_r == CNT_W'(DB_CYCLES)) begin
                db_r    <= s2_r;
                cnt_r   <= {CNT_W{1'b0}};
                press_r <= ~s2_r;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign press_pulse = press_r;

endmodule

// File: rtl/keypad_entry.sv
// Debounced select button + cursor decode feeding a decimal entry
// accumulator whose completed value leaves over a valid/ready handshake.
module keypad_entry
    import pos_pkg::*;
#(
    parameter int DB_CYCLES  = 1000000,
    parameter int MAX_DIGITS = 6,
    parameter int VAL_W      = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_sel,
    input  logic [3:0]       cursor_x,
    input  logic [3:0]       cursor_y,
    output logic             key_strobe,
    output logic [3:0]       key_code,
    output logic [VAL_W-1:0] cur_value,
    output logic [3:0]       digit_count,
    output logic             entry_valid,
    output logic [VAL_W-1:0] entry_value,
    input  logic             entry_ready,
    output logic             overflow
);

    logic             press_s;
    logic [4:0]       decode_s;
    logic [VAL_W-1:0] digit_ext_s;
    logic [VAL_W-1:0] times_ten_s;

    logic             key_strobe_r;
    logic [3:0]       key_code_r;
    logic [VAL_W-1:0] cur_value_r;
    logic [3:0]       digit_count_r;
    logic             entry_valid_r;
    logic [VAL_W-1:0] entry_value_r;
    logic             overflow_r;
    logic [0:0]       state_r;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_sel_db (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_sel),
        .press_pulse (press_s)
    );

    // Decode the cursor and form the shift-add x10 for the accumulator.
    always_comb begin
        decode_s    = decode_key(cursor_x, cursor_y);
        digit_ext_s = {{(VAL_W-4){1'b0}}, key_code_r};
        times_ten_s = (cur_value_r << 3) + (cur_value_r << 1);
    end

    // Register the decoded key; off-grid presses are dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_strobe_r <= 1'b0;
            key_code_r   <= 4'd0;
        end else begin
            key_strobe_r <= press_s & decode_s[4];
            if (press_s && decode_s[4]) begin
                key_code_r <= decode_s[3:0];
            end else begin
                key_code_r <= key_code_r;
            end
        end
    end

    // Entry FSM: accumulate digits, then hold the value until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_ENTRY;
            cur_value_r   <= {VAL_W{1'b0}};
            digit_count_r <= 4'd0;
            entry_valid_r <= 1'b0;
            entry_value_r <= {VAL_W{1'b0}};
            overflow_r    <= 1'b0;
        end else begin
            overflow_r <= 1'b0;
            case (state_r)
                S_ENTRY: begin
                    if (key_strobe_r) begin
                        if (key_code_r <= KEY_MAX_DIGIT) begin
                            if (digit_count_r < 4'(MAX_DIGITS)) begin
                                cur_value_r   <= times_ten_s + digit_ext_s;
                                digit_count_r <= digit_count_r + 4'd1;
                            end else begin
                                overflow_r <= 1'b1;
                            end
                        end else if (key_code_r == KEY_CLEAR) begin
                            cur_value_r   <= {VAL_W{1'b0}};
                            digit_count_r <= 4'd0;
                        end else if ((key_code_r == KEY_ENTER) && (digit_count_r != 4'd0)) begin
                            entry_value_r <= cur_value_r;
                            entry_valid_r <= 1'b1;
                            state_r       <= S_OUT;
                        end else begin
                            state_r <= S_ENTRY;
                        end
                    end
                end
                S_OUT: begin
                    // Keys are ignored here, including one coinciding with the handshake.
                    if (entry_valid_r && entry_ready) begin
                        entry_valid_r <= 1'b0;
                        cur_value_r   <= {VAL_W{1'b0}};
                        digit_count_r <= 4'd0;
                        state_r       <= S_ENTRY;
                    end
                end
                default: begin
                    state_r <= S_ENTRY;
                end
            endcase
        end
    end

    assign key_strobe  = key_strobe_r;
    assign key_code    = key_code_r;
    assign cur_value   = cur_value_r;
    assign digit_count = digit_count_r;
    assign entry_valid = entry_valid_r;
    assign entry_value = entry_value_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: stimulus queues expected key and entry
// results, monitors pop and compare when the DUT presents them.
module tb_keypad_entry;

    localparam int DB  = 4;
    localparam int MD  = 6;
    localparam int VW  = 20;

    typedef struct {
        logic [3:0]    code;
        logic [VW-1:0] val;
        logic [3:0]    cnt;
        logic          ovf;
    } key_exp_t;

    logic          clk;
    logic          rst;
    logic          btn_sel;
    logic [3:0]    cursor_x;
    logic [3:0]    cursor_y;
    logic          key_strobe;
    logic [3:0]    key_code;
    logic [VW-1:0] cur_value;
    logic [3:0]    digit_count;
    logic          entry_valid;
    logic [VW-1:0] entry_value;
    logic          entry_ready;
    logic          overflow;

    key_exp_t      key_q[$];
    logic [VW-1:0] entry_q[$];
    int            checks;
    int            errors;
    int            strobe_seen;
    int            ovf_seen;

    keypad_entry #(.DB_CYCLES(DB), .MAX_DIGITS(MD), .VAL_W(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_sel     (btn_sel),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .cur_value   (cur_value),
        .digit_count (digit_count),
        .entry_valid (entry_valid),
        .entry_value (entry_value),
        .entry_ready (entry_ready),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_key(input logic [3:0] code, input logic [VW-1:0] val,
                            input logic [3:0] cnt, input logic ovf);
        key_exp_t e;
        e.code = code;
        e.val  = val;
        e.cnt  = cnt;
        e.ovf  = ovf;
        key_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        cursor_x = x;
        cursor_y = y;
        btn_sel  = 1'b0;
        repeat (10) @(negedge clk);
        btn_sel = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_exp(input logic [3:0] x, input logic [3:0] y, input logic [3:0] code,
                             input logic [VW-1:0] val, input logic [3:0] cnt, input logic ovf);
        push_key(code, val, cnt, ovf);
        press(x, y);
    endtask

    // Key monitor: code on the strobe, accumulator result one cycle later.
    initial begin
        key_exp_t e;
        forever begin
            @(negedge clk);
            if (key_strobe === 1'b1) begin
                strobe_seen++;
                if (key_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got code %0d expected no strobe", key_code);
                end else begin
                    e = key_q.pop_front();
                    check("key_code", 32'(key_code), 32'(e.code));
                    @(negedge clk);
                    check("cur_value", 32'(cur_value), 32'(e.val));
                    check("digit_count", 32'(digit_count), 32'(e.cnt));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                end
            end
        end
    end

    // Entry monitor: compare the value at the handshake cycle.
    initial begin
        logic [VW-1:0] ev;
        forever begin
            @(negedge clk);
            if ((entry_valid === 1'b1) && (entry_ready === 1'b1)) begin
                if (entry_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got %0d expected none", entry_value);
                end else begin
                    ev = entry_q.pop_front();
                    check("entry_value", 32'(entry_value), 32'(ev));
                end
            end
        end
    end

    // Overflow pulse counter.
    initial begin
        forever begin
            @(negedge clk);
            if (overflow === 1'b1) ovf_seen++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int first;
        int s0;
        checks      = 0;
        errors      = 0;
        strobe_seen = 0;
        ovf_seen    = 0;
        rst         = 1'b1;
        btn_sel     = 1'b1;
        cursor_x    = 4'd0;
        cursor_y    = 4'd0;
        entry_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_key_strobe", 32'(key_strobe), 32'd0);
        check("rst_cur_value", 32'(cur_value), 32'd0);
        check("rst_digit_count", 32'(digit_count), 32'd0);
        check("rst_entry_valid", 32'(entry_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // First press with edge-exact strobe timing: edge 3+DB.
        push_key(4'd2, 20'd2, 4'd1, 1'b0);
        @(negedge clk);
        cursor_x = 4'd1;
        cursor_y = 4'd0;
        btn_sel  = 1'b0;
        first    = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if ((key_strobe === 1'b1) && (first < 0)) first = i;
        end
        check("strobe_edge", 32'(first), 32'd7);
        @(negedge clk);
        btn_sel = 1'b1;
        repeat (10) @(negedge clk);

        // Three-cycle glitch is shorter than the debounce window.
        s0 = strobe_seen;
        btn_sel = 1'b0;
        repeat (3) @(negedge clk);
        btn_sel = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_strobes", 32'(strobe_seen), 32'(s0));
        check("glitch_value", 32'(cur_value), 32'd2);

        // Clear, enter 123, ENTER with consumer stalled.
        press_exp(4'd0, 4'd3, 4'hA, 20'd0, 4'd0, 1'b0);
        press_exp(4'd0, 4'd0, 4'd1, 20'd1, 4'd1, 1'b0);
        press_exp(4'd1, 4'd0, 4'd2, 20'd12, 4'd2, 1'b0);
        press_exp(4'd2, 4'd0, 4'd3, 20'd123, 4'd3, 1'b0);
        entry_q.push_back(20'd123);
        press_exp(4'd2, 4'd3, 4'hB, 20'd123, 4'd3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(entry_valid), 32'd1);
            check("hold_value", 32'(entry_value), 32'd123);
        end
        // A key while the entry is pending strobes but leaves the value alone.
        press_exp(4'd0, 4'd1, 4'd4, 20'd123, 4'd3, 1'b0);
        @(posedge clk);
        #1;
        entry_ready = 1'b1;
        @(posedge clk);
        #1;
        entry_ready = 1'b0;
        check("hs_valid", 32'(entry_valid), 32'd0);
        check("hs_cur_value", 32'(cur_value), 32'd0);
        check("hs_digit_count", 32'(digit_count), 32'd0);

        // Seven nines: the seventh is dropped with one overflow pulse.
        press_exp(4'd2, 4'd2, 4'd9, 20'd9, 4'd1, 1'b0);
        press_exp(4'd2, 4'd2, 4'd9, 20'd99, 4'd2, 1'b0);
        press_exp(4'd2, 4'd2, 4'd9, 20'd999, 4'd3, 1'b0);
        press_exp(4'd2, 4'd2, 4'd9, 20'd9999, 4'd4, 1'b0);
        press_exp(4'd2, 4'd2, 4'd9, 20'd99999, 4'd5, 1'b0);
        press_exp(4'd2, 4'd2, 4'd9, 20'd999999, 4'd6, 1'b0);
        press_exp(4'd2, 4'd2, 4'd9, 20'd999999, 4'd6, 1'b1);
        press_exp(4'd0, 4'd3, 4'hA, 20'd0, 4'd0, 1'b0);

        // 4, 5, CLEAR, then ENTER on an empty entry is ignored.
        press_exp(4'd0, 4'd1, 4'd4, 20'd4, 4'd1, 1'b0);
        press_exp(4'd1, 4'd1, 4'd5, 20'd45, 4'd2, 1'b0);
        press_exp(4'd0, 4'd3, 4'hA, 20'd0, 4'd0, 1'b0);
        press_exp(4'd2, 4'd3, 4'hB, 20'd0, 4'd0, 1'b0);
        check("empty_enter_valid", 32'(entry_valid), 32'd0);

        // Off-grid cursor produces no strobe.
        s0 = strobe_seen;
        press(4'd3, 4'd1);
        check("offgrid_strobes", 32'(strobe_seen), 32'(s0));
        check("offgrid_value", 32'(cur_value), 32'd0);

        // Reset while an entry is pending drops it.
        press_exp(4'd1, 4'd2, 4'd8, 20'd8, 4'd1, 1'b0);
        press_exp(4'd2, 4'd3, 4'hB, 20'd8, 4'd1, 1'b0);
        check("pre_rst_valid", 32'(entry_valid), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_entry_valid", 32'(entry_valid), 32'd0);
        check("mid_rst_entry_value", 32'(entry_value), 32'd0);
        check("mid_rst_cur_value", 32'(cur_value), 32'd0);
        check("mid_rst_digit_count", 32'(digit_count), 32'd0);
        check("mid_rst_key_strobe", 32'(key_strobe), 32'd0);
        rst = 1'b0;

        // Back in the entry state: a digit accumulates again.
        press_exp(4'd0, 4'd2, 4'd7, 20'd7, 4'd1, 1'b0);

        repeat (5) @(negedge clk);
        check("key_q_drained", 32'(key_q.size()), 32'd0);
        check("entry_q_drained", 32'(entry_q.size()), 32'd0);
        check("overflow_pulses", 32'(ovf_seen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
